// File: rtl/rvv_pkg.sv
// Shared RVV definitions: instruction width, instruction type, default
// instruction-queue depth and the occupancy classes of the queue.
package rvv_pkg;

    localparam int INSN_WIDTH       = 32;
    localparam int INSN_QUEUE_DEPTH = 8;

    typedef logic [INSN_WIDTH-1:0] insn_t;

    // Occupancy class of the instruction queue, derived from its count.
    typedef enum logic [1:0] {
        Q_EMPTY  = 2'd0,
        Q_ACTIVE = 2'd1,
        Q_FULL   = 2'd2
    } q_state_e;

endpackage

// File: rtl/rvv_insn_ram.sv
// DEPTH x WIDTH instruction storage: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module rvv_insn_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming instruction into its slot on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rvv_insn_queue.sv
// Instruction queue feeding rvv_proc_main. Buffers issued RVV instructions
// in a DEPTH-entry FIFO and presents the oldest one until the processor
// takes it. Optional same-cycle bypass when empty: RVV_INSN_QUEUE_BYPASS_EN.
module rvv_insn_queue
    import rvv_pkg::*;
#(
    parameter int INSN_WIDTH = rvv_pkg::INSN_WIDTH,
    parameter int DEPTH      = rvv_pkg::INSN_QUEUE_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [INSN_WIDTH-1:0] insn_in,
    input  logic                  insn_valid_in,
    output logic                  insn_ready_out,
    output logic [INSN_WIDTH-1:0] insn_out,
    output logic                  insn_valid,
    input  logic                  proc_rdy,
    output logic [PTR_W:0]        count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);

    logic [PTR_W:0]        wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]        wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [INSN_WIDTH-1:0] head_s;
    q_state_e              state_s;
    logic                  bypass_s;
    logic                  push_s, pop_s, wr_en_s, rd_en_s;

    // Extra pointer bit tells a full queue from an empty one.
    assign count = wr_ptr_r - rd_ptr_r;

    // Classify occupancy from the count.
    always_comb begin
        state_s = Q_ACTIVE;
        if (count == CNT_ZERO) begin
            state_s = Q_EMPTY;
        end else if (count == CNT_FULL) begin
            state_s = Q_FULL;
        end else begin
            state_s = Q_ACTIVE;
        end
    end

    // Status flags from the occupancy class.
    always_comb begin
        empty = 1'b0;
        full  = 1'b0;
        case (state_s)
            Q_EMPTY:  begin empty = 1'b1; full = 1'b0; end
            Q_ACTIVE: begin empty = 1'b0; full = 1'b0; end
            Q_FULL:   begin empty = 1'b0; full = 1'b1; end
            default:  begin empty = 1'b0; full = 1'b0; end
        endcase
    end

`ifdef RVV_INSN_QUEUE_BYPASS_EN
    // An issued instruction is shown to the processor in the same cycle when empty.
    assign bypass_s = empty && insn_valid_in && !flush && rst_n;
`else
    assign bypass_s = 1'b0;
`endif

    // Ready looks only at registered state, flush and reset, never at proc_rdy.
    assign insn_ready_out = !full && !flush && rst_n;
    assign insn_valid     = (!empty || bypass_s) && !flush;

    assign push_s  = insn_valid_in && insn_ready_out;
    assign pop_s   = insn_valid && proc_rdy;
    // A bypassed instruction taken immediately is never stored.
    assign wr_en_s = push_s && !(bypass_s && proc_rdy);
    assign rd_en_s = pop_s && !empty;

    // Head instruction, forced to zero while nothing valid is presented.
    always_comb begin
        insn_out = {INSN_WIDTH{1'b0}};
        if (!insn_valid) begin
            insn_out = {INSN_WIDTH{1'b0}};
        end else if (bypass_s) begin
            insn_out = insn_in;
        end else begin
            insn_out = head_s;
        end
    end

    // Pointer advance; flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (flush) begin
            wr_ptr_nxt_s = CNT_ZERO;
            rd_ptr_nxt_s = CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
    end

    // Pointer registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= CNT_ZERO;
            rd_ptr_r <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    rvv_insn_ram #(
        .WIDTH (INSN_WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s && !flush),
        .waddr (wr_ptr_r[PTR_W-1:0]),
        .wdata (insn_in),
        .raddr (rd_ptr_r[PTR_W-1:0]),
        .rdata (head_s)
    );

endmodule

// File: tb/tb_rvv_insn_queue.sv
// Directed self-checking bench for rvv_insn_queue (DEPTH 8, 32-bit insns).
module tb_rvv_insn_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush, insn_valid_in, proc_rdy;
    logic [31:0] insn_in;
    logic        insn_ready_out, insn_valid, empty, full;
    logic [31:0] insn_out;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    rvv_insn_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .insn_in        (insn_in),
        .insn_valid_in  (insn_valid_in),
        .insn_ready_out (insn_ready_out),
        .insn_out       (insn_out),
        .insn_valid     (insn_valid),
        .proc_rdy       (proc_rdy),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vec(input int i);
        return 32'h0000_0057 + 32'(i) * 32'h0200_8000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; insn_valid_in = 1'b0; proc_rdy = 1'b0; insn_in = 32'h0;
        #2;
        check("rst_ready", 32'(insn_ready_out), 32'd0);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_out", insn_out, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(insn_ready_out), 32'd1);

        // Fill with proc_rdy low.
        for (int i = 0; i < 8; i++) begin
            insn_in = vec(i); insn_valid_in = 1'b1;
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_head", insn_out, 32'h0000_0057);
        end
        #1;
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(insn_ready_out), 32'd0);
        insn_in = 32'hDEAD_BEEF;
        tick();
        check("ninth_count", 32'(count), 32'd8);
        check("ninth_head", insn_out, 32'h0000_0057);

        // Drain in order.
        insn_valid_in = 1'b0; proc_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_valid", 32'(insn_valid), 32'd1);
            check("drain_out", insn_out, vec(i));
            tick();
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_valid_lo", 32'(insn_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // Streaming: one push and one pop per cycle.
        proc_rdy = 1'b0; insn_in = 32'h1000_0000; insn_valid_in = 1'b1;
        tick();
        proc_rdy = 1'b1;
        for (int i = 1; i < 20; i++) begin
            insn_in = 32'h1000_0000 + 32'(i);
            #1;
            check("stream_out", insn_out, 32'h1000_0000 + 32'(i - 1));
            check("stream_count", 32'(count), 32'd1);
            tick();
        end
        insn_valid_in = 1'b0;
        #1;
        check("stream_last", insn_out, 32'h1000_0013);
        tick();
        check("stream_end_count", 32'(count), 32'd0);

        // Wrap-around: 3 pushes, 3 pops, 8 pushes, drain.
        proc_rdy = 1'b0; insn_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            insn_in = 32'h2000_0000 + 32'(i);
            tick();
        end
        insn_valid_in = 1'b0; proc_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wrap_pre_out", insn_out, 32'h2000_0000 + 32'(i));
            tick();
        end
        proc_rdy = 1'b0; insn_valid_in = 1'b1;
        for (int i = 3; i < 11; i++) begin
            insn_in = 32'h2000_0000 + 32'(i);
            tick();
        end
        insn_valid_in = 1'b0;
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_count", 32'(count), 32'd8);
        proc_rdy = 1'b1;
        for (int i = 3; i < 11; i++) begin
            #1;
            check("wrap_out", insn_out, 32'h2000_0000 + 32'(i));
            tick();
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Flush at count 5 with a simultaneous push.
        proc_rdy = 1'b0; insn_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            insn_in = 32'h3000_0000 + 32'(i);
            tick();
        end
        check("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; insn_in = 32'hBAD0_0BAD;
        #1;
        check("flush_ready", 32'(insn_ready_out), 32'd0);
        check("flush_valid", 32'(insn_valid), 32'd0);
        tick();
        flush = 1'b0; insn_valid_in = 1'b0;
        #1;
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_valid", 32'(insn_valid), 32'd0);
        insn_in = 32'h3100_0001; insn_valid_in = 1'b1;
        tick();
        insn_valid_in = 1'b0;
        check("post_flush_head", insn_out, 32'h3100_0001);
        check("post_flush_one", 32'(count), 32'd1);
        proc_rdy = 1'b1;
        tick();
        proc_rdy = 1'b0;
        check("post_flush_drained", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle at count 3.
        insn_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            insn_in = 32'h4000_0000 + 32'(i);
            tick();
        end
        insn_valid_in = 1'b0;
        check("pre_areset_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(insn_valid), 32'd0);
        check("areset_out", insn_out, 32'h0);
        check("areset_count", 32'(count), 32'd0);
        check("areset_ready", 32'(insn_ready_out), 32'd0);
        check("areset_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("areset_release_ready", 32'(insn_ready_out), 32'd1);

        // Push into an empty queue with proc_rdy high.
        insn_in = 32'h5E00_30D7; insn_valid_in = 1'b1; proc_rdy = 1'b1;
        #1;
`ifdef RVV_INSN_QUEUE_BYPASS_EN
        check("bypass_valid", 32'(insn_valid), 32'd1);
        check("bypass_out", insn_out, 32'h5E00_30D7);
        tick();
        insn_valid_in = 1'b0;
        check("bypass_count", 32'(count), 32'd0);
`else
        check("nobypass_valid", 32'(insn_valid), 32'd0);
        check("nobypass_out", insn_out, 32'h0);
        tick();
        insn_valid_in = 1'b0;
        check("nobypass_count", 32'(count), 32'd1);
        check("nobypass_head", insn_out, 32'h5E00_30D7);
        tick();
        check("nobypass_drained", 32'(count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvv_insn_queue.md
# rvv_insn_queue

Instruction queue directly upstream of `rvv_proc_main`. It accepts 32-bit RVV instructions from the issuing side through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the oldest instruction on `insn_out`/`insn_valid` and retires it only when `rvv_proc_main` asserts `proc_rdy`. Stimulus no longer has to hold or replay instructions while the processor stalls.

## Interface
Parameters:
- `INSN_WIDTH`, 32, instruction width in bits.
- `DEPTH`, 8, number of FIFO entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`, local; pointer index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear.
- `insn_in`  in  INSN_WIDTH  instruction from the issuer.
- `insn_valid_in`  in  1  `insn_in` is valid.
- `insn_ready_out`  out  1  queue can accept an instruction this cycle.
- `insn_out`  out  INSN_WIDTH  head instruction to `rvv_proc_main.insn_in`.
- `insn_valid`  out  1  `insn_out` is valid; drives `rvv_proc_main.insn_valid`.
- `proc_rdy`  in  1  processor accepts the head this cycle.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.

## Operation
- **push** = `insn_valid_in && insn_ready_out`. It writes `insn_in` to `mem[wr_ptr]` and increments `wr_ptr`.
- **pop** = `insn_valid && proc_rdy`. It increments `rd_ptr`.
- **Pointers** are PTR_W+1 bits. The low bits index `mem` and wrap from DEPTH-1 to 0. The MSB distinguishes full from empty. `count = wr_ptr - rd_ptr`.
- **States**, encoded by `count`:
  - EMPTY (0), ACTIVE (1..DEPTH-1), FULL (DEPTH).
  - Push only: `count+1`.
  - Pop only: `count-1`.
  - Push and pop together: `count` unchanged.
  - Flush: go to EMPTY.
- **Output conditions:**
  - `insn_ready_out = !full && !flush && rst_n`.
  - `insn_valid = !empty && !flush`.
  - `insn_out = mem[rd_ptr]` when `insn_valid`, otherwise 0.
- **Push at FULL:** refused, because ready is low. A pop in the same cycle does not open a slot until the next cycle.
- **Flush priority:** `flush` beats push and pop. Pointers and `count` clear on the next edge, and a same-cycle push is dropped.
- **Reset:** clears both pointers. `mem` contents are not reset.

## Timing
- **Reset values:**
  - `insn_ready_out` 0 while `rst_n` low, 1 from the first cycle after release.
  - `insn_valid` 0, `insn_out` 0, `count` 0.
  - `empty` 1, `full` 0.
- **Latency:** push to `insn_valid` is one cycle. An instruction pushed at edge N is visible after edge N and can pop at edge N+1.
- **Throughput:** one push and one pop per cycle, sustained.
- **Combinational paths:** `insn_ready_out` depends only on registered state, `flush` and `rst_n`. It has no combinational path from `proc_rdy`.
- **Stall:** `insn_out` is held stable while `insn_valid && !proc_rdy`.
- **Reset mid-operation:** asynchronous clear. Queued instructions are lost, and outputs take their reset values immediately.

## Configuration
- **`RVV_INSN_QUEUE_BYPASS_EN` defined:** when EMPTY and `insn_valid_in` is high:
  - `insn_valid = 1` and `insn_out = insn_in` in the same cycle.
  - If `proc_rdy` is also high, the instruction is consumed without being written and `count` stays 0.
  - If `proc_rdy` is low, the instruction is written normally.
  - Zero-cycle latency; this adds a combinational path from `insn_in` to `insn_out`.
- **Macro undefined:** strictly registered, with one-cycle latency as above.

## Structure
- **Shared package `rvv_pkg`:**
  - `INSN_WIDTH` constant.
  - `insn_t` typedef (`logic [INSN_WIDTH-1:0]`).
  - Default `INSN_QUEUE_DEPTH`.
- **Sub-module `rvv_insn_ram`:** DEPTH×INSN_WIDTH storage with one synchronous write port and one asynchronous read port. Pointer and count logic stay in `rvv_insn_queue`.

## Test plan
- **Reset, then fill:** reset, then push 0x00000057, 0x02008057, … with `proc_rdy=0` for 8 cycles.
  - `count` reaches 8, `full=1`, `insn_ready_out=0`.
  - A 9th push is refused.
  - `insn_out` stays 0x00000057.
- **Drain:** from FULL, set `proc_rdy=1` with no pushes. Instructions pop in push order, one per cycle; after 8 cycles `empty=1` and `insn_valid=0`.
- **Streaming:** push and pop every cycle for 20 instructions. `count` stays 1, and the output order matches the input order.
- **Wrap-around:** 3 pushes, 3 pops, then 8 pushes. `full=1`, the pointers wrap, and pops return the last 8 instructions in order.
- **Flush:** assert `flush` at `count=5` with a simultaneous push. Next cycle `count=0` and `insn_valid=0`, and the pushed instruction never appears.
- **Async reset and bypass:**
  - Drop `rst_n` mid-cycle at `count=3`: outputs go to reset values immediately.
  - With `RVV_INSN_QUEUE_BYPASS_EN`: while EMPTY, push 0x5E0030D7 with `proc_rdy=1`. `insn_valid=1` with `insn_out=0x5E0030D7` in the same cycle, and `count` stays 0.
